// File: rtl/axi_rd_slave.sv
// Fixed-length AXI read-data burst source: captures beats from a free-running
// DATA_IN into a small FIFO and drains them under RREADY back-pressure.
module axi_rd_slave #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              key,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] S_RDATA,
  output logic              S_RVALID,
  output logic              S_RLAST,
  input  logic              M_RREADY,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(BURST_LEN + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cap_cnt;
  logic [CW-1:0]     r_beat_cnt;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_last;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == OW'(FIFO_DEPTH));
  assign w_last   = (r_beat_cnt == CW'(BURST_LEN - 1));
  assign w_pop    = S_RVALID & M_RREADY;

  // All outputs are functions of registered state only.
  assign S_RVALID = ~w_empty;
  assign S_RLAST  = S_RVALID & w_last;
  assign S_RDATA  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fullness is taken before any same-edge pop, so a full FIFO never accepts a push.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        w_push = (r_cap_cnt < CW'(BURST_LEN)) && !w_full;
        if (w_pop && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters and FIFO pointers; everything clears on the way back to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap_cnt  <= '0;
      r_beat_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (r_state == ST_DONE) begin
      r_cap_cnt  <= '0;
      r_beat_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_cap_cnt <= r_cap_cnt + CW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OW'(1);
        2'b01:   r_count <= r_count - OW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= DATA_IN;
  end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: queue-based reference model with randomized
// back-pressure, plus a directed BURST_LEN=1 / FIFO_DEPTH=2 instance.
module tb_axi_rd_slave;

  localparam int unsigned W     = 32;
  localparam int unsigned LEN   = 16;
  localparam int unsigned DEPTH = 4;

  logic         clk;
  logic         rstn;
  logic         key;
  logic [W-1:0] data_in;
  logic [W-1:0] s_rdata;
  logic         s_rvalid;
  logic         s_rlast;
  logic         rready;
  logic         busy;
  logic         done;

  logic         key1;
  logic [W-1:0] data_in1;
  logic [W-1:0] s_rdata1;
  logic         s_rvalid1;
  logic         s_rlast1;
  logic         rready1;
  logic         busy1;
  logic         done1;

  axi_rd_slave #(.DATA_W(W), .BURST_LEN(LEN), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .key(key), .DATA_IN(data_in),
    .S_RDATA(s_rdata), .S_RVALID(s_rvalid), .S_RLAST(s_rlast),
    .M_RREADY(rready), .busy(busy), .done(done)
  );

  axi_rd_slave #(.DATA_W(W), .BURST_LEN(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .key(key1), .DATA_IN(data_in1),
    .S_RDATA(s_rdata1), .S_RVALID(s_rvalid1), .S_RLAST(s_rlast1),
    .M_RREADY(rready1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 burst, 2 done; queue holds captured beats.
  int           m_ph    = 0;
  int           m_cap   = 0;
  int           m_beats = 0;
  logic [W-1:0] mq[$];

  // Observations of the DUT over the current burst.
  logic [W-1:0] obs_data[$];
  int           obs_hs   = 0;
  int           obs_last = 0;
  int           n_done   = 0;

  logic         p_valid = 1'b0;
  logic         p_ready = 1'b0;
  logic         p_last  = 1'b0;
  logic [W-1:0] p_data  = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic k, input logic r, input logic [W-1:0] d);
    int  pre;
    bit  hs;
    bit  fin;
    bit  push;
    pre  = mq.size();
    hs   = (pre > 0) && r;
    fin  = hs && (m_beats == LEN - 1);
    push = (m_ph == 1) && (m_cap < LEN) && (pre < DEPTH);
    if (hs) begin
      mq.delete(0);
      m_beats++;
    end
    if (push) begin
      mq.push_back(d);
      m_cap++;
    end
    case (m_ph)
      0: if (k) m_ph = 1;
      1: if (fin) m_ph = 2;
      default: begin
        m_ph = 0; m_cap = 0; m_beats = 0; mq.delete();
      end
    endcase
  endtask

  task automatic model_reset();
    m_ph = 0; m_cap = 0; m_beats = 0; mq.delete();
    p_valid = 1'b0; p_ready = 1'b0;
  endtask

  // One clock: drive at negedge, check before the edge, step the model at the edge.
  task automatic cycle(input logic k, input logic r);
    logic         ev;
    logic [W-1:0] ed;
    key     = k;
    rready  = r;
    data_in = data_in + 32'd1;
    #1;
    ev = (mq.size() > 0);
    ed = ev ? mq[0] : '0;
    chk("rvalid", W'(s_rvalid), W'(ev));
    chk("rdata",  s_rdata, ed);
    chk("rlast",  W'(s_rlast), W'(ev && (m_beats == LEN - 1)));
    chk("busy",   W'(busy), W'(m_ph != 0));
    chk("done",   W'(done), W'(m_ph == 2));
    if (p_valid && !p_ready) begin
      chk("hold_valid", W'(s_rvalid), 32'd1);
      chk("hold_data",  s_rdata, p_data);
      chk("hold_last",  W'(s_rlast), W'(p_last));
    end
    p_valid = s_rvalid; p_ready = r; p_data = s_rdata; p_last = s_rlast;
    if (s_rvalid && r) begin
      obs_hs++;
      if (s_rlast) obs_last++;
      obs_data.push_back(s_rdata);
    end
    if (done) n_done++;
    @(posedge clk);
    model_edge(k, r, data_in);
    @(negedge clk);
  endtask

  // mode 0: ready high; 1: stalled 10 cycles; 2: random ready; 3: random + mid-burst key.
  task automatic run_burst(input int mode, output int done_cyc, output logic [W-1:0] d1);
    logic r;
    logic k;
    int   prev_done;
    obs_data.delete();
    obs_hs = 0; obs_last = 0; n_done = 0; done_cyc = -1; d1 = '0;
    cycle(1'b1, (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(1)));
    for (int i = 1; i < 400; i++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (i >= 10) : 1'($urandom_range(1));
      k = (mode == 3) && (i == 6);
      prev_done = n_done;
      cycle(k, r);
      if (i == 1) d1 = data_in;
      if (n_done != prev_done) done_cyc = i;
      if (m_ph == 0) break;
    end
    chk("burst_end", W'(busy), 32'd0);
    chk("hs_cnt",    W'(obs_hs), W'(LEN));
    chk("rlast_cnt", W'(obs_last), 32'd1);
    chk("done_cnt",  W'(n_done), 32'd1);
  endtask

  initial begin
    int           dcyc;
    logic [W-1:0] d1;
    logic [W-1:0] b1;

    rstn = 1'b0; key = 1'b0; rready = 1'b0; data_in = $urandom;
    key1 = 1'b0; rready1 = 1'b0; data_in1 = $urandom;
    @(negedge clk); @(negedge clk);
    chk("rst_rvalid", W'(s_rvalid), 32'd0);
    chk("rst_rdata",  s_rdata, 32'd0);
    chk("rst_rlast",  W'(s_rlast), 32'd0);
    chk("rst_busy",   W'(busy), 32'd0);
    chk("rst_done",   W'(done), 32'd0);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    // Full-rate burst: consecutive data from the E1 sample, done at a fixed offset.
    run_burst(0, dcyc, d1);
    chk("t1_done_cyc", W'(dcyc), 32'd18);
    for (int i = 0; i < obs_data.size(); i++) chk("t1_data", obs_data[i], d1 + W'(i));
    cycle(1'b0, 1'b1);

    // Stalled start: FIFO fills with D..D+3, capture resumes after the first pop.
    run_burst(1, dcyc, d1);
    for (int i = 0; i < 4; i++) chk("t2_fill", obs_data[i], d1 + W'(i));
    chk("t2_gap",  obs_data[4],  d1 + 32'd10);
    chk("t2_tail", obs_data[15], d1 + 32'd21);

    // Back-to-back random back-pressure bursts.
    for (int b = 0; b < 3; b++) run_burst(2, dcyc, d1);

    // Retrigger mid-burst is ignored.
    run_burst(3, dcyc, d1);

    // Asynchronous reset after beat 5 discards the burst.
    obs_hs = 0; n_done = 0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 50 && obs_hs < 5; i++) cycle(1'b0, 1'b1);
    chk("t5_beats", W'(obs_hs), 32'd5);
    #1 rstn = 1'b0;
    #1;
    chk("t5_rvalid", W'(s_rvalid), 32'd0);
    chk("t5_rdata",  s_rdata, 32'd0);
    chk("t5_rlast",  W'(s_rlast), 32'd0);
    chk("t5_busy",   W'(busy), 32'd0);
    chk("t5_done",   W'(done), 32'd0);
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    model_reset();
    n_done = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk("t5_no_done", W'(n_done), 32'd0);
    run_burst(0, dcyc, d1);
    for (int i = 0; i < obs_data.size(); i++) chk("t5_data", obs_data[i], d1 + W'(i));

    // Single-beat build: RVALID and RLAST together, held under stall, then done.
    key1 = 1'b1; rready1 = 1'b0; data_in1 = $urandom;
    #1 chk("t6_idle_valid", W'(s_rvalid1), 32'd0);
    @(posedge clk); @(negedge clk);
    key1 = 1'b0; b1 = $urandom; data_in1 = b1;
    #1 chk("t6_busy", W'(busy1), 32'd1);
    chk("t6_pre_valid", W'(s_rvalid1), 32'd0);
    @(posedge clk); @(negedge clk);
    data_in1 = ~b1;
    #1 chk("t6_valid", W'(s_rvalid1), 32'd1);
    chk("t6_last", W'(s_rlast1), 32'd1);
    chk("t6_data", s_rdata1, b1);
    @(posedge clk); @(negedge clk);
    #1 chk("t6_hold_valid", W'(s_rvalid1), 32'd1);
    chk("t6_hold_data", s_rdata1, b1);
    chk("t6_hold_last", W'(s_rlast1), 32'd1);
    chk("t6_no_done", W'(done1), 32'd0);
    rready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    rready1 = 1'b0;
    #1 chk("t6_done", W'(done1), 32'd1);
    chk("t6_empty", W'(s_rvalid1), 32'd0);
    chk("t6_zero_data", s_rdata1, 32'd0);
    chk("t6_busy_done", W'(busy1), 32'd1);
    @(posedge clk); @(negedge clk);
    #1 chk("t6_done_clr", W'(done1), 32'd0);
    chk("t6_idle", W'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_rd_slave.md
# axi_rd_slave

Read-direction counterpart of the existing AXI write-data path. On a start pulse it sources one fixed-length burst on a simplified AXI read-data channel (RDATA/RVALID/RLAST with RREADY back-pressure). Beats are captured from a free-running `DATA_IN` source into a small internal FIFO, so the channel tolerates arbitrary master stalls. It sits opposite a read master in the same bench and fabric position as the write slave.

## Interface
- `DATA_W`, 32: data width.
- `BURST_LEN`, 16: beats per burst, legal range 1..256.
- `FIFO_DEPTH`, 4: output FIFO entries, a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `key`  in  1  start request, level sampled on `clk`.
- `DATA_IN`  in  DATA_W  beat source, sampled when captured.
- `S_RDATA`  out  DATA_W  read data, equal to the FIFO head.
- `S_RVALID`  out  1  beat valid.
- `S_RLAST`  out  1  final beat of the burst.
- `M_RREADY`  in  1  master ready.
- `busy`  out  1  burst in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE: FIFO empty, counters zero.
  - BURST: capturing and emitting beats.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - IDLE → BURST when `key`=1 at a clock edge.
  - BURST → DONE on the edge where the last beat handshakes (`S_RVALID & M_RREADY & S_RLAST`).
  - DONE → IDLE unconditionally.
- `key` is ignored outside IDLE; no queuing, no retrigger.
- Capture (BURST only):
  - Push `DATA_IN` when `cap_cnt < BURST_LEN` and the FIFO is not full. `cap_cnt` increments per push.
  - Fullness is evaluated before any same-edge pop, so there is no push into a full FIFO even if a pop occurs on that edge.
- Emit:
  - `S_RVALID` = FIFO not empty.
  - Handshake = `S_RVALID & M_RREADY`; it pops the FIFO and increments `beat_cnt`.
  - `S_RLAST` = `S_RVALID & (beat_cnt == BURST_LEN-1)`.
- Counters are `$clog2(BURST_LEN+1)` bits wide; no wrap occurs within a burst. Both clear on entry to IDLE.
- FIFO: read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. Occupancy is `$clog2(FIFO_DEPTH)+1` bits. Push and pop on the same edge are both performed, leaving occupancy unchanged.
- AXI rules:
  - Once `S_RVALID` is high, it and `S_RDATA`/`S_RLAST` hold stable until the handshake.
  - `S_RVALID` never depends combinationally on `M_RREADY`.
  - `M_RREADY` may toggle freely.
- Reset (any time, including mid-burst):
  - State → IDLE; FIFO and counters clear.
  - All outputs go 0 immediately (asynchronously): `S_RDATA`=0, `S_RVALID`=0, `S_RLAST`=0, `busy`=0, `done`=0.
  - The partial burst is discarded with no `S_RLAST` and no `done`.

## Timing
- Edge E0: `key`=1 sampled in IDLE; `busy`=1 after E0.
- Edge E1: first push captures `DATA_IN` as present before E1. `S_RVALID`=1 in the cycle after E1, giving 2 edges of start-to-valid latency.
- With `M_RREADY`=1 throughout: one beat per cycle, no bubbles. Last handshake occurs at edge E1+BURST_LEN.
- `done`=1 for exactly the cycle after the final handshake. `busy`=0 one cycle later.
- `BURST_LEN`=1: the first beat carries `S_RLAST`=1.
- `S_RDATA` is 0 whenever the FIFO is empty. All outputs are registered or derived from registered state only.

## Test plan
1. Reset, then `key` pulse with `DATA_IN` a counter and `M_RREADY`=1 → 16 beats.
   - Data is D, D+1, …, D+15, where D is `DATA_IN` at E1.
   - `S_RLAST` only on beat 16; `done` pulses once; `busy` drops after.
2. `M_RREADY`=0 for 10 cycles after start, then 1 → FIFO holds 4 consecutive values D..D+3 and capture stalls.
   - After release, the beat sequence shows a gap after D+3.
   - `S_RDATA`/`S_RVALID` stay stable while stalled.
   - Exactly 16 beats, `S_RLAST` on the 16th.
3. Random `M_RREADY` pattern, 3 back-to-back bursts → each burst has 16 handshakes, one `S_RLAST` and one `done`. No valid-drop-without-handshake violations.
4. `key` asserted again mid-burst → ignored; the burst still completes with exactly 16 beats.
5. `rstn` low for 1 cycle after beat 5 → all outputs 0 immediately, no `done`.
   - A new `key` afterwards produces a full 16-beat burst starting from fresh capture.
6. `BURST_LEN`=1, `FIFO_DEPTH`=2 build → a single beat with `S_RVALID` and `S_RLAST` both high, then `done` the next cycle.
